// File: rtl/l2_tag_directory.sv
// Set-associative tag/MESI-state directory for the L2 cache model: tag compare, victim
// choice, MESI state write-back with per-set tree pseudo-LRU, and access statistics.
module l2_tag_directory #(
    parameter int SETS       = 16,
    parameter int WAYS       = 8,
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 64,
    localparam int OFF_W     = $clog2(LINE_BYTES),
    localparam int IDX_W     = $clog2(SETS),
    localparam int TAG_W     = ADDR_W - IDX_W - OFF_W,
    localparam int WAY_W     = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd,
    input  logic [ADDR_W-1:0] addr,
    output logic              lookup_valid,
    output logic [1:0]        mesi_bits,
    output logic              miss,
    output logic [WAY_W-1:0]  lookup_way,
    input  logic              mesi_valid,
    input  logic [1:0]        mesi_returned,
    output logic              victim_valid,
    output logic              victim_dirty,
    output logic [TAG_W-1:0]  victim_tag,
    output logic              done,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic [31:0]       rd_cnt,
    output logic [31:0]       wr_cnt
);

    localparam int NODE_W = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_UPDATE = 3'd3;
    localparam logic [2:0] ST_CLEAR  = 3'd4;

    localparam logic [1:0] MESI_I = 2'd0;
    localparam logic [1:0] MESI_M = 2'd3;

    localparam logic [3:0] CMD_WR   = 4'd1;
    localparam logic [3:0] CMD_L1RD = 4'd2;
    localparam logic [3:0] CMD_SNPW = 4'd6;
    localparam logic [3:0] CMD_CLR  = 4'd8;

    // Victim walk: each node bit says which half holds the replacement candidate.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] tree);
        logic [NODE_W-1:0] node;
        logic [WAY_W-1:0]  way;
        logic              b;
        node = '0;
        way  = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b    = tree[node];
            way  = (way << 1) | WAY_W'(b);
            node = (node << 1) + NODE_W'(1) + NODE_W'(b);
        end
        return way;
    endfunction

    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] tree,
                                                   input logic [WAY_W-1:0] way);
        logic [NODE_W-1:0] node;
        logic [WAYS-2:0]   t;
        logic              b;
        t    = tree;
        node = '0;
        for (int lvl = 0; lvl < WAY_W; lvl++) begin
            b       = way[WAY_W-1-lvl];
            t[node] = ~b;
            node    = (node << 1) + NODE_W'(1) + NODE_W'(b);
        end
        return t;
    endfunction

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [3:0]       cmd_q;
    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    logic [IDX_W-1:0] clr_idx_q;
    logic [1:0]       ret_q;

    logic             cmd_ready_q;
    logic             lookup_valid_q;
    logic [1:0]       mesi_bits_q;
    logic             miss_q;
    logic [WAY_W-1:0] lookup_way_q;
    logic             victim_valid_q;
    logic             victim_dirty_q;
    logic [TAG_W-1:0] victim_tag_q;
    logic             done_q;
    logic [31:0]      hit_cnt_q;
    logic [31:0]      miss_cnt_q;
    logic [31:0]      rd_cnt_q;
    logic [31:0]      wr_cnt_q;

    logic [1:0]       way_st_q  [SETS][WAYS];
    logic [TAG_W-1:0] way_tag_q [SETS][WAYS];
    logic [WAYS-2:0]  plru_q    [SETS];

    logic             accept_s;
    logic             in_lookup_s;
    logic             in_clr_s;
    logic             cpu_s;
    logic [WAYS-1:0]  valid_s;
    logic [WAYS-1:0]  match_s;
    logic             hit_s;
    logic [WAY_W-1:0] hit_way_s;
    logic [WAY_W-1:0] free_way_s;
    logic [WAY_W-1:0] victim_way_s;
    logic [1:0]       vic_st_s;
    logic             vic_valid_s;

    assign accept_s    = cmd_valid & cmd_ready_q;
    assign in_lookup_s = (cmd <= CMD_SNPW);
    assign in_clr_s    = (cmd == CMD_CLR);
    assign cpu_s       = (cmd_q <= CMD_L1RD);

    // Tag compare over the latched set; lowest-index invalid way is preferred for fills.
    always_comb begin
        hit_way_s  = '0;
        free_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            valid_s[w] = (way_st_q[idx_q][w] != MESI_I);
            match_s[w] = valid_s[w] && (way_tag_q[idx_q][w] == tag_q);
            hit_way_s  = match_s[w] ? WAY_W'(w) : hit_way_s;
            free_way_s = valid_s[w] ? free_way_s : WAY_W'(w);
        end
        hit_s        = |match_s;
        victim_way_s = (&valid_s) ? plru_victim(plru_q[idx_q]) : free_way_s;
        vic_st_s     = way_st_q[idx_q][victim_way_s];
        vic_valid_s  = (vic_st_s != MESI_I);
    end

    // Next-state logic of the command FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_lookup_s) begin
                    state_d = ST_LOOKUP;
                end else if (accept_s && in_clr_s) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mesi_valid) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_UPDATE: state_d = ST_IDLE;
            ST_CLEAR: begin
                if (clr_idx_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, command latch and registered handshake/lookup outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cmd_q          <= 4'd0;
            idx_q          <= '0;
            tag_q          <= '0;
            clr_idx_q      <= '0;
            ret_q          <= MESI_I;
            cmd_ready_q    <= 1'b0;
            lookup_valid_q <= 1'b0;
            mesi_bits_q    <= MESI_I;
            miss_q         <= 1'b0;
            lookup_way_q   <= '0;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
            victim_tag_q   <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        cmd_q     <= cmd;
                        idx_q     <= addr[OFF_W+IDX_W-1:OFF_W];
                        tag_q     <= addr[ADDR_W-1:OFF_W+IDX_W];
                        clr_idx_q <= '0;
                        done_q    <= ~(in_lookup_s | in_clr_s);
                    end
                end
                ST_LOOKUP: begin
                    lookup_valid_q <= 1'b1;
                    if (hit_s) begin
                        miss_q         <= 1'b0;
                        mesi_bits_q    <= way_st_q[idx_q][hit_way_s];
                        lookup_way_q   <= hit_way_s;
                        victim_valid_q <= 1'b0;
                        victim_dirty_q <= 1'b0;
                        victim_tag_q   <= '0;
                    end else if (cpu_s) begin
                        miss_q         <= 1'b1;
                        mesi_bits_q    <= MESI_I;
                        lookup_way_q   <= victim_way_s;
                        victim_valid_q <= vic_valid_s;
                        victim_dirty_q <= (vic_st_s == MESI_M);
                        victim_tag_q   <= vic_valid_s ? way_tag_q[idx_q][victim_way_s] : '0;
                    end else begin
                        miss_q         <= 1'b1;
                        mesi_bits_q    <= MESI_I;
                        lookup_way_q   <= '0;
                        victim_valid_q <= 1'b0;
                        victim_dirty_q <= 1'b0;
                        victim_tag_q   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (mesi_valid) begin
                        lookup_valid_q <= 1'b0;
                        ret_q          <= mesi_returned;
                        done_q         <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    clr_idx_q <= clr_idx_q + IDX_W'(1);
                    done_q    <= (clr_idx_q == IDX_W'(SETS - 2));
                end
                default: lookup_valid_q <= 1'b0;
            endcase
        end
    end

    // Way state/tag/PLRU storage; snoop misses leave the set untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    way_st_q[s][w]  <= MESI_I;
                    way_tag_q[s][w] <= '0;
                end
            end
        end else if (state_q == ST_CLEAR) begin
            plru_q[clr_idx_q] <= '0;
            for (int w = 0; w < WAYS; w++) begin
                way_st_q[clr_idx_q][w] <= MESI_I;
            end
        end else if ((state_q == ST_UPDATE) && (!miss_q || cpu_s)) begin
            way_st_q[idx_q][lookup_way_q] <= ret_q;
            if (miss_q) begin
                way_tag_q[idx_q][lookup_way_q] <= tag_q;
            end
            if (cpu_s) begin
                plru_q[idx_q] <= plru_touch(plru_q[idx_q], lookup_way_q);
            end
        end
    end

    // Statistics: CPU-side commands only, cleared when a CLR is accepted.
    always_ff @(posedge clk) begin
        if (rst || (accept_s && in_clr_s)) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
            rd_cnt_q   <= 32'd0;
            wr_cnt_q   <= 32'd0;
        end else if ((state_q == ST_UPDATE) && cpu_s) begin
            hit_cnt_q  <= hit_cnt_q + {31'd0, ~miss_q};
            miss_cnt_q <= miss_cnt_q + {31'd0, miss_q};
            rd_cnt_q   <= rd_cnt_q + {31'd0, (cmd_q != CMD_WR)};
            wr_cnt_q   <= wr_cnt_q + {31'd0, (cmd_q == CMD_WR)};
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign lookup_valid = lookup_valid_q;
    assign mesi_bits    = mesi_bits_q;
    assign miss         = miss_q;
    assign lookup_way   = lookup_way_q;
    assign victim_valid = victim_valid_q;
    assign victim_dirty = victim_dirty_q;
    assign victim_tag   = victim_tag_q;
    assign done         = done_q;
    assign hit_cnt      = hit_cnt_q;
    assign miss_cnt     = miss_cnt_q;
    assign rd_cnt       = rd_cnt_q;
    assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_l2_tag_directory.sv
// Scoreboard bench for l2_tag_directory: a behavioural directory model predicts each lookup,
// a negedge monitor compares it while lookup_valid is high.
module tb_l2_tag_directory;

    localparam logic [1:0] ST_I = 2'd0;
    localparam logic [1:0] ST_S = 2'd1;
    localparam logic [1:0] ST_E = 2'd2;
    localparam logic [1:0] ST_M = 2'd3;

    typedef struct packed {
        logic        miss;
        logic [1:0]  st;
        logic [2:0]  way;
        logic        chk_way;
        logic        vv;
        logic        vd;
        logic [21:0] vtag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic        lookup_valid;
    logic [1:0]  mesi_bits;
    logic        miss;
    logic [2:0]  lookup_way;
    logic        mesi_valid;
    logic [1:0]  mesi_returned;
    logic        victim_valid;
    logic        victim_dirty;
    logic [21:0] victim_tag;
    logic        done;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int err_cnt = 0;
    int chk_cnt = 0;
    exp_t exp_q[$];

    logic [1:0]  m_st   [16][8];
    logic [21:0] m_tag  [16][8];
    logic [6:0]  m_plru [16];
    logic [31:0] m_hit, m_miss, m_rd, m_wr;

    logic        obs_miss, obs_vv, obs_vd;
    logic [1:0]  obs_st;
    logic [2:0]  obs_way;
    logic [21:0] obs_vtag;

    l2_tag_directory dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .addr(addr), .lookup_valid(lookup_valid), .mesi_bits(mesi_bits), .miss(miss),
        .lookup_way(lookup_way), .mesi_valid(mesi_valid), .mesi_returned(mesi_returned),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .done(done), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, act, exp);
        end
    endtask

    function automatic int tb_victim(input logic [6:0] t);
        int lo = 0, sz = 8, n = 0;
        while (sz > 1) begin
            sz = sz / 2;
            if (t[n]) begin lo = lo + sz; n = 2 * n + 2; end
            else      begin n = 2 * n + 1; end
        end
        return lo;
    endfunction

    function automatic logic [6:0] tb_touch(input logic [6:0] t_in, input int w);
        logic [6:0] t = t_in;
        int lo = 0, sz = 8, n = 0;
        while (sz > 1) begin
            sz = sz / 2;
            if (w >= lo + sz) begin t[n] = 1'b0; lo = lo + sz; n = 2 * n + 2; end
            else              begin t[n] = 1'b1; n = 2 * n + 1; end
        end
        return t;
    endfunction

    function automatic logic [31:0] mk_addr(input int tag, input int set);
        logic [31:0] a;
        a = (32'(tag) << 10) | (32'(set) << 6);
        return a;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 16; s++) begin
            m_plru[s] = 7'd0;
            for (int w = 0; w < 8; w++) begin m_st[s][w] = ST_I; m_tag[s][w] = 22'd0; end
        end
        m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
    endtask

    task automatic model_expect(input logic [3:0] c, input logic [31:0] a,
                                output exp_t e, output bit hit, output int way);
        int set = int'(a[9:6]);
        logic [21:0] t = a[31:10];
        int free_w = -1;
        hit = 0; way = 0; e = '0; e.chk_way = 1'b1;
        for (int w = 0; w < 8; w++)
            if (m_st[set][w] != ST_I && m_tag[set][w] == t) begin hit = 1; way = w; end
        for (int w = 7; w >= 0; w--)
            if (m_st[set][w] == ST_I) free_w = w;
        if (hit) begin
            e.st = m_st[set][way]; e.way = 3'(way);
        end else if (c <= 4'd2) begin
            way = (free_w >= 0) ? free_w : tb_victim(m_plru[set]);
            e.miss = 1'b1; e.way = 3'(way);
            e.vv = (m_st[set][way] != ST_I);
            e.vd = (m_st[set][way] == ST_M);
            e.vtag = e.vv ? m_tag[set][way] : 22'd0;
        end else begin
            e.miss = 1'b1; e.chk_way = 1'b0;
        end
    endtask

    task automatic model_update(input logic [3:0] c, input logic [31:0] a, input logic [1:0] ret,
                                input bit hit, input int way);
        int set = int'(a[9:6]);
        if (hit || c <= 4'd2) begin
            m_st[set][way] = ret;
            if (!hit) m_tag[set][way] = a[31:10];
        end
        if (c <= 4'd2) begin
            m_plru[set] = tb_touch(m_plru[set], way);
            if (hit) m_hit++; else m_miss++;
            if (c == 4'd1) m_wr++; else m_rd++;
        end
    endtask

    task automatic check_counters(input string tag);
        check_val({tag, "_hit"},  hit_cnt,  m_hit);
        check_val({tag, "_miss"}, miss_cnt, m_miss);
        check_val({tag, "_rd"},   rd_cnt,   m_rd);
        check_val({tag, "_wr"},   wr_cnt,   m_wr);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 40) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 1'b0; mesi_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", cmd_ready, 0);
        check_val("rst_lookup_valid", lookup_valid, 0);
        check_val("rst_done", done, 0);
        check_val("rst_cnt", hit_cnt | miss_cnt | rd_cnt | wr_cnt, 0);
        rst = 1'b0;
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        check_val("rst_ready_after", cmd_ready, 1);
    endtask

    task automatic do_cmd(input logic [3:0] c, input logic [31:0] a, input logic [1:0] ret,
                          input int stall, input bit hold_print);
        exp_t e; bit hit; int way; int n;
        wait_ready();
        hit = 0; way = 0;
        if (c <= 4'd6) begin model_expect(c, a, e, hit, way); exp_q.push_back(e); end
        cmd = c; addr = a; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (c <= 4'd6) begin
            n = 0;
            while (!lookup_valid && n < 20) begin @(posedge clk); #1; n++; end
            if (!lookup_valid) begin check_val("lookup_timeout", 32'd0, 32'd1); return; end
            check_val("lookup_latency", n, 1);
            obs_miss = miss; obs_st = mesi_bits; obs_way = lookup_way;
            obs_vv = victim_valid; obs_vd = victim_dirty; obs_vtag = victim_tag;
            if (hold_print) begin cmd = 4'd9; cmd_valid = 1'b1; end
            for (int i = 0; i < stall; i++) begin
                if (hold_print) begin
                    check_val("stall_ready", cmd_ready, 0);
                    check_val("stall_done", done, 0);
                end
                @(posedge clk); #1;
            end
            mesi_returned = ret; mesi_valid = 1'b1;
            @(posedge clk); #1;
            mesi_valid = 1'b0;
            check_val("upd_done", done, 1);
            check_val("upd_lookup_valid", lookup_valid, 0);
            model_update(c, a, ret, hit, way);
            @(posedge clk); #1;
            check_val("idle_done", done, 0);
            check_val("idle_ready", cmd_ready, 1);
            if (hold_print) begin
                @(posedge clk); #1;
                cmd_valid = 1'b0;
                check_val("held_print_done", done, 1);
                check_val("held_print_ready", cmd_ready, 1);
                @(posedge clk); #1;
            end
        end else begin
            check_val("print_done", done, 1);
            check_val("print_ready", cmd_ready, 1);
            @(posedge clk); #1;
            check_val("print_done_end", done, 0);
        end
    endtask

    task automatic do_clear();
        wait_ready();
        cmd = 4'd8; addr = 32'd0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_val("clr_ready", cmd_ready, 0);
            check_val("clr_done", done, (i == 15) ? 32'd1 : 32'd0);
            @(posedge clk); #1;
        end
        check_val("clr_ready_end", cmd_ready, 1);
        check_val("clr_done_end", done, 0);
        for (int s = 0; s < 16; s++) begin
            m_plru[s] = 7'd0;
            for (int w = 0; w < 8; w++) m_st[s][w] = ST_I;
        end
        m_hit = 0; m_miss = 0; m_rd = 0; m_wr = 0;
    endtask

    // Scoreboard monitor: outputs must match (and stay) while lookup_valid is high.
    logic lv_prev = 1'b0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (lookup_valid) begin
            if (exp_q.size() == 0) begin
                check_val("sb_unexpected_lookup", 32'd1, 32'd0);
            end else begin
                e = exp_q[0];
                check_val("sb_miss", miss, e.miss);
                check_val("sb_mesi", mesi_bits, e.st);
                if (e.chk_way) check_val("sb_way", lookup_way, e.way);
                check_val("sb_vvalid", victim_valid, e.vv);
                check_val("sb_vdirty", victim_dirty, e.vd);
                check_val("sb_vtag", victim_tag, e.vtag);
            end
        end
        if (lv_prev && !lookup_valid && exp_q.size() > 0) void'(exp_q.pop_front());
        lv_prev = lookup_valid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e; bit hit; int way; int n; int r;
        logic [3:0] c;
        rst = 1'b1; cmd_valid = 1'b0; cmd = 4'd0; addr = 32'd0;
        mesi_valid = 1'b0; mesi_returned = 2'd0;

        // 1: read miss then hit in set 1
        do_reset();
        do_cmd(4'd0, 32'h0000_0040, ST_E, 0, 0);
        check_val("t1_miss", obs_miss, 1);
        check_val("t1_mesi", obs_st, ST_I);
        check_val("t1_way", obs_way, 0);
        check_val("t1_vvalid", obs_vv, 0);
        do_cmd(4'd0, 32'h0000_0040, ST_S, 1, 0);
        check_val("t1_hit_miss", obs_miss, 0);
        check_val("t1_hit_mesi", obs_st, ST_E);
        check_val("t1_hit_cnt", hit_cnt, 1);
        check_val("t1_miss_cnt", miss_cnt, 1);
        check_val("t1_rd_cnt", rd_cnt, 2);

        // 2: nine distinct write tags into set 1 evict the first (dirty) line
        do_reset();
        for (int t = 1; t <= 9; t++) do_cmd(4'd1, mk_addr(t, 1), ST_M, 0, 0);
        check_val("t2_way", obs_way, 0);
        check_val("t2_vvalid", obs_vv, 1);
        check_val("t2_vdirty", obs_vd, 1);
        check_val("t2_vtag", obs_vtag, 1);
        check_val("t2_wr_cnt", wr_cnt, 9);
        check_val("t2_miss_cnt", miss_cnt, 9);

        // 3: snoop miss on an empty cache allocates nothing and counts nothing
        do_reset();
        do_cmd(4'd4, 32'h1234_5680, ST_S, 0, 0);
        check_val("t3_miss", obs_miss, 1);
        check_val("t3_mesi", obs_st, ST_I);
        check_val("t3_vvalid", obs_vv, 0);
        check_val("t3_cnt", hit_cnt | miss_cnt | rd_cnt | wr_cnt, 0);
        do_cmd(4'd0, 32'h1234_5680, ST_E, 0, 0);
        check_val("t3_not_allocated", obs_miss, 1);

        // 4: fill three sets, clear, prior line gone
        do_reset();
        for (int s = 2; s <= 4; s++) do_cmd(4'd0, mk_addr(s + 5, s), ST_S, 0, 0);
        do_cmd(4'd1, mk_addr(7, 2), ST_M, 0, 0);
        do_clear();
        check_counters("t4_after_clr");
        check_val("t4_cnt_zero", hit_cnt | miss_cnt | rd_cnt | wr_cnt, 0);
        do_cmd(4'd0, mk_addr(7, 2), ST_E, 0, 0);
        check_val("t4_prior_miss", obs_miss, 1);

        // 5: reset while waiting for the MESI stage
        do_cmd(4'd0, mk_addr(3, 5), ST_E, 0, 0);
        model_expect(4'd0, mk_addr(4, 5), e, hit, way);
        exp_q.push_back(e);
        cmd = 4'd0; addr = mk_addr(4, 5); cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!lookup_valid && n < 20) begin @(posedge clk); #1; n++; end
        check_val("t5_in_wait", lookup_valid, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("t5_lookup_valid", lookup_valid, 0);
        check_val("t5_ready_in_rst", cmd_ready, 0);
        @(posedge clk); #1;
        check_val("t5_ready_after", cmd_ready, 1);
        check_val("t5_lookup_valid_after", lookup_valid, 0);
        exp_q.delete();
        model_reset();
        do_cmd(4'd0, mk_addr(4, 5), ST_S, 0, 0);
        check_val("t5_line_absent", obs_miss, 1);

        // 6: command held through a 10-cycle stall, then PRINT/ignored opcodes
        do_cmd(4'd1, mk_addr(4, 5), ST_M, 10, 1);
        check_counters("t6_held");
        do_cmd(4'd9, mk_addr(4, 5), ST_I, 0, 0);
        do_cmd(4'd7, mk_addr(4, 5), ST_I, 0, 0);
        do_cmd(4'd12, mk_addr(4, 5), ST_I, 0, 0);
        check_counters("t6_print");
        do_cmd(4'd0, mk_addr(4, 5), ST_M, 0, 0);
        check_val("t6_still_present", obs_miss, 0);

        // Random mix over a few hot sets to exercise PLRU eviction and snoops
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 29);
            if (r == 0) begin
                do_clear();
            end else if (r == 1) begin
                c = 4'($urandom_range(9, 15));
                do_cmd(c, 32'd0, ST_I, 0, 0);
            end else begin
                c = 4'($urandom_range(0, 6));
                do_cmd(c, mk_addr($urandom_range(1, 11), $urandom_range(0, 2)),
                       2'($urandom_range(0, 3)), $urandom_range(0, 3), 0);
            end
        end
        check_counters("final");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
